// File: rtl/tap_controller_if.sv
// JTAG pin and data-register control bundle between the board side and the TAP controller.
// Pure wiring; TCK and TRSTn travel as plain ports beside it.
interface tap_controller_if #(
    parameter int IrWidth = 4
);
    logic               TMS;
    logic               TDI;
    logic               BypassTDO;
    logic               DataTDO;
    logic [3:0]         State;
    logic               TLResetN;
    logic               CaptureDR;
    logic               ShiftDR;
    logic               ClockDR;
    logic               UpdateDR;
    logic [IrWidth-1:0] Instruction;
    logic               ExtestSelect;
    logic               SampleSelect;
    logic               IdcodeSelect;
    logic               BypassSelect;
    logic               TDO;
    logic               TDOEnable;

    modport master (
        output TMS, TDI, BypassTDO, DataTDO,
        input  State, TLResetN, CaptureDR, ShiftDR, ClockDR, UpdateDR, Instruction,
               ExtestSelect, SampleSelect, IdcodeSelect, BypassSelect, TDO, TDOEnable
    );

    modport slave (
        input  TMS, TDI, BypassTDO, DataTDO,
        output State, TLResetN, CaptureDR, ShiftDR, ClockDR, UpdateDR, Instruction,
               ExtestSelect, SampleSelect, IdcodeSelect, BypassSelect, TDO, TDOEnable
    );
endinterface

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP: 16-state FSM, IR, one-hot DR selects, ClockDR/UpdateDR and falling-edge TDO mux.
// State moves on rising TCK; strobes and TDO are retimed half a cycle later; no backpressure.
module tap_controller #(
    parameter int                 IrWidth      = 4,
    parameter logic [IrWidth-1:0] ExtestOpcode = 4'b0000,
    parameter logic [IrWidth-1:0] SampleOpcode = 4'b0011,
    parameter logic [IrWidth-1:0] IdcodeOpcode = 4'b0010,
    parameter logic [IrWidth-1:0] IrCapture    = 4'b0001
) (
    input  logic            TCK,
    input  logic            TRSTn,
    tap_controller_if.slave jtag
);

    typedef enum logic [3:0] {
        TLR      = 4'hF,
        RTI      = 4'hC,
        SEL_DR   = 4'h7,
        CAP_DR   = 4'h6,
        SH_DR    = 4'h2,
        EX1_DR   = 4'h1,
        PAUSE_DR = 4'h3,
        EX2_DR   = 4'h0,
        UPD_DR   = 4'h5,
        SEL_IR   = 4'h4,
        CAP_IR   = 4'hE,
        SH_IR    = 4'hA,
        EX1_IR   = 4'h9,
        PAUSE_IR = 4'hB,
        EX2_IR   = 4'h8,
        UPD_IR   = 4'hD
    } tap_state_t;

    tap_state_t         state;
    tap_state_t         state_nxt;
    logic [IrWidth-1:0] ir_shift;
    logic [IrWidth-1:0] instr;
    logic               clk_en;
    logic               update_dr;
    logic               tdo;
    logic               tdo_en;
    logic               sel_extest;
    logic               sel_sample;
    logic               sel_idcode;
    logic               sel_bypass;

    always_ff @(posedge TCK or negedge TRSTn) begin
        if (!TRSTn) begin
            state <= TLR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            TLR:      state_nxt = jtag.TMS ? TLR      : RTI;
            RTI:      state_nxt = jtag.TMS ? SEL_DR   : RTI;
            SEL_DR:   state_nxt = jtag.TMS ? SEL_IR   : CAP_DR;
            CAP_DR:   state_nxt = jtag.TMS ? EX1_DR   : SH_DR;
            SH_DR:    state_nxt = jtag.TMS ? EX1_DR   : SH_DR;
            EX1_DR:   state_nxt = jtag.TMS ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: state_nxt = jtag.TMS ? EX2_DR   : PAUSE_DR;
            EX2_DR:   state_nxt = jtag.TMS ? UPD_DR   : SH_DR;
            UPD_DR:   state_nxt = jtag.TMS ? SEL_DR   : RTI;
            SEL_IR:   state_nxt = jtag.TMS ? TLR      : CAP_IR;
            CAP_IR:   state_nxt = jtag.TMS ? EX1_IR   : SH_IR;
            SH_IR:    state_nxt = jtag.TMS ? EX1_IR   : SH_IR;
            EX1_IR:   state_nxt = jtag.TMS ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: state_nxt = jtag.TMS ? EX2_IR   : PAUSE_IR;
            EX2_IR:   state_nxt = jtag.TMS ? UPD_IR   : SH_IR;
            UPD_IR:   state_nxt = jtag.TMS ? SEL_DR   : RTI;
            default:  state_nxt = TLR;
        endcase
    end

    // IR shift stage: LSB leaves first, TDI enters at the MSB.
    always_ff @(posedge TCK or negedge TRSTn) begin
        if (!TRSTn) begin
            ir_shift <= IrCapture;
        end else if (state == CAP_IR) begin
            ir_shift <= IrCapture;
        end else if (state == SH_IR) begin
            ir_shift <= {jtag.TDI, ir_shift[IrWidth-1:1]};
        end
    end

    // Falling-edge side: the instruction and every DR strobe settle while TCK is low,
    // so ClockDR gating cannot glitch and selects are stable before the next Capture-DR.
    always_ff @(negedge TCK or negedge TRSTn) begin
        if (!TRSTn) begin
            instr     <= IdcodeOpcode;
            clk_en    <= 1'b0;
            update_dr <= 1'b0;
            tdo       <= 1'b0;
            tdo_en    <= 1'b0;
        end else begin
            if (state == TLR) begin
                instr <= IdcodeOpcode;
            end else if (state == UPD_IR) begin
                instr <= ir_shift;
            end
            clk_en    <= (state == CAP_DR) || (state == SH_DR);
            update_dr <= (state == UPD_DR);
            tdo_en    <= (state == SH_IR) || (state == SH_DR);
            if (state == SH_IR) begin
                tdo <= ir_shift[0];
            end else if (state == SH_DR) begin
                tdo <= sel_bypass ? jtag.BypassTDO : jtag.DataTDO;
            end
        end
    end

    always_comb begin
        sel_extest = 1'b0;
        sel_sample = 1'b0;
        sel_idcode = 1'b0;
        sel_bypass = 1'b0;
        if (instr == ExtestOpcode) begin
            sel_extest = 1'b1;
        end else if (instr == SampleOpcode) begin
            sel_sample = 1'b1;
        end else if (instr == IdcodeOpcode) begin
            sel_idcode = 1'b1;
        end else begin
            sel_bypass = 1'b1;
        end
    end

    assign jtag.State        = state;
    assign jtag.TLResetN     = (state != TLR);
    assign jtag.CaptureDR    = (state == CAP_DR);
    assign jtag.ShiftDR      = (state == SH_DR);
    assign jtag.ClockDR      = TCK & clk_en;
    assign jtag.UpdateDR     = update_dr;
    assign jtag.Instruction  = instr;
    assign jtag.ExtestSelect = sel_extest;
    assign jtag.SampleSelect = sel_sample;
    assign jtag.IdcodeSelect = sel_idcode;
    assign jtag.BypassSelect = sel_bypass;
    assign jtag.TDO          = tdo;
    assign jtag.TDOEnable    = tdo_en;

endmodule

// File: tb/tb_tap_controller.sv
// Directed bench for tap_controller: stimulus walks the TAP and queues expected TDO bits,
// a monitor pops them on every falling TCK where TDOEnable is high.
module tb_tap_controller;

    logic TCK;
    logic TRSTn;
    logic byp;
    logic data_tdo;
    logic sh_s;
    logic tdi_s;
    int   clkdr_cnt;
    int   vectors;
    int   miscompares;
    logic tdo_q[$];

    tap_controller_if #(.IrWidth(4)) jif();

    tap_controller dut (
        .TCK   (TCK),
        .TRSTn (TRSTn),
        .jtag  (jif.slave)
    );

    assign jif.BypassTDO = byp;
    assign jif.DataTDO   = data_tdo;

    initial TCK = 1'b0;
    always #5 TCK = ~TCK;

    // Attached bypass register: captures 0 outside Shift-DR, shifts TDI inside it.
    always @(negedge TCK) begin
        #3;
        sh_s  = jif.ShiftDR;
        tdi_s = jif.TDI;
    end

    always @(posedge jif.ClockDR) begin
        byp <= sh_s & tdi_s;
        clkdr_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always begin
        logic exp_bit;
        @(negedge TCK);
        #1;
        check("select_onehot",
              32'($onehot({jif.ExtestSelect, jif.SampleSelect, jif.IdcodeSelect, jif.BypassSelect})), 1);
        if (jif.TDOEnable === 1'b1) begin
            if (tdo_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL tdo_unexpected: got TDO=%b with nothing expected at %0t", jif.TDO, $time);
            end else begin
                exp_bit = tdo_q.pop_front();
                check("tdo", jif.TDO, exp_bit);
            end
        end
    end

    task automatic step(input logic tms, input logic tdi, input logic [3:0] exp_state);
        jif.TMS = tms;
        jif.TDI = tdi;
        @(posedge TCK);
        #1;
        check("state", jif.State, exp_state);
        check("shift_dr", jif.ShiftDR, exp_state == 4'h2);
        check("capture_dr", jif.CaptureDR, exp_state == 4'h6);
        check("tlreset_n", jif.TLResetN, exp_state != 4'hF);
        @(negedge TCK);
        #2;
    endtask

    // From RTI: capture 4'b0001 shifts out LSB first while v shifts in.
    task automatic load_ir(input logic [3:0] v);
        tdo_q.push_back(1'b1);
        tdo_q.push_back(1'b0);
        tdo_q.push_back(1'b0);
        tdo_q.push_back(1'b0);
        step(1, 0, 4'h7);
        step(1, 0, 4'h4);
        step(0, 0, 4'hE);
        step(0, 0, 4'hA);
        for (int i = 0; i < 4; i++) begin
            step(i == 3, v[i], (i == 3) ? 4'h9 : 4'hA);
        end
        step(1, 0, 4'hD);
        step(0, 0, 4'hC);
    endtask

    // From RTI: Capture-DR then n Shift-DR edges; optional 3-cycle pause after pause_at edges.
    task automatic dr_scan(input logic [7:0] d, input int n, input int pause_at,
                           input logic [7:0] exp_tdo, input logic hold);
        int   cnt0;
        int   cnt_p;
        logic ex;
        for (int i = 0; i < n; i++) tdo_q.push_back(exp_tdo[i]);
        cnt0 = clkdr_cnt;
        step(1, 0, 4'h7);
        step(0, 0, 4'h6);
        step(0, 0, 4'h2);
        for (int i = 0; i < n; i++) begin
            ex = (i == n - 1) || (i == pause_at - 1);
            step(ex, d[i], ex ? 4'h1 : 4'h2);
            if (ex && (i != n - 1)) begin
                step(0, 0, 4'h3);
                cnt_p = clkdr_cnt;
                step(0, 0, 4'h3);
                step(0, 0, 4'h3);
                check("pause_tdo_held", jif.TDO, hold);
                check("pause_tdo_en", jif.TDOEnable, 0);
                step(1, 0, 4'h0);
                check("pause_clockdr_idle", clkdr_cnt, cnt_p);
                step(0, 0, 4'h2);
            end
        end
        step(1, 0, 4'h5);
        check("update_dr_high", jif.UpdateDR, 1);
        step(0, 0, 4'hC);
        check("update_dr_low", jif.UpdateDR, 0);
        check("clockdr_pulses", clkdr_cnt - cnt0, n + 1);
    endtask

    task automatic check_sel(input logic [3:0] instr, input logic [3:0] sel);
        check("instruction", jif.Instruction, instr);
        check("selects", {jif.ExtestSelect, jif.SampleSelect, jif.IdcodeSelect, jif.BypassSelect}, sel);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clkdr_cnt   = 0;
        byp         = 1'b0;
        data_tdo    = 1'b1;
        jif.TMS     = 1'b1;
        jif.TDI     = 1'b0;
        TRSTn       = 1'b1;
        #1 TRSTn    = 1'b0;
        #2;
        check("rst_state", jif.State, 4'hF);
        check("rst_tlreset_n", jif.TLResetN, 0);
        check_sel(4'b0010, 4'b0010);
        check("rst_clockdr", jif.ClockDR, 0);
        check("rst_update_dr", jif.UpdateDR, 0);
        check("rst_tdo", jif.TDO, 0);
        check("rst_tdo_en", jif.TDOEnable, 0);

        @(negedge TCK);
        #2;
        TRSTn = 1'b1;
        step(1, 0, 4'hF);
        step(0, 0, 4'hC);

        // Asynchronous reset mid-Shift-DR with TCK high and ClockDR running.
        step(1, 0, 4'h7);
        step(0, 0, 4'h6);
        tdo_q.push_back(1'b1);
        tdo_q.push_back(1'b1);
        step(0, 0, 4'h2);
        step(0, 0, 4'h2);
        @(posedge TCK);
        #2;
        TRSTn = 1'b0;
        #1;
        check("trst_state", jif.State, 4'hF);
        check("trst_tlreset_n", jif.TLResetN, 0);
        check_sel(4'b0010, 4'b0010);
        check("trst_tdo_en", jif.TDOEnable, 0);
        check("trst_clockdr", jif.ClockDR, 0);
        @(negedge TCK);
        #2;
        TRSTn = 1'b1;
        step(1, 0, 4'hF);
        step(0, 0, 4'hC);

        load_ir(4'b1111);
        check_sel(4'b1111, 4'b0001);

        // Bypass: 0 first, then TDI 8'b10110010 delayed one cycle.
        dr_scan(8'b1011_0010, 8, 0, 8'b0110_0100, 1'b0);
        // Bypass with a pause after three shifts; no bit may be lost.
        dr_scan(8'b0001_1010, 6, 3, 8'b0011_0100, 1'b1);

        load_ir(4'b0101);
        check_sel(4'b0101, 4'b0001);
        load_ir(4'b0000);
        check_sel(4'b0000, 4'b1000);
        load_ir(4'b0011);
        check_sel(4'b0011, 4'b0100);

        // Five TMS=1 edges from RTI.
        step(1, 0, 4'h7);
        step(1, 0, 4'h4);
        step(1, 0, 4'hF);
        step(1, 0, 4'hF);
        step(1, 0, 4'hF);
        check_sel(4'b0010, 4'b0010);
        step(0, 0, 4'hC);

        // Five TMS=1 edges from Shift-IR; Update-IR on the way latches 4'b0000.
        tdo_q.push_back(1'b1);
        step(1, 0, 4'h7);
        step(1, 0, 4'h4);
        step(0, 0, 4'hE);
        step(0, 0, 4'hA);
        step(1, 0, 4'h9);
        step(1, 0, 4'hD);
        check_sel(4'b0000, 4'b1000);
        step(1, 0, 4'h7);
        step(1, 0, 4'h4);
        step(1, 0, 4'hF);
        check_sel(4'b0010, 4'b0010);

        repeat (3) @(negedge TCK);
        #2;
        check("scoreboard_drained", tdo_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
